weight_bias_responder: RTL and testbench
========================================

Name: weight_bias_responder

Overview:
Memory-side responder for the arbitrated weight/bias read requests issued by the convolution/FC layers. Holds the weight and bias tables in two internal banks, preloaded over a load port. Serves one weight read and one bias read per cycle, with fixed 1-cycle latency and a valid strobe. Sits directly downstream of the weight/bias arbiter, whose read_*_signal_data/addr_data outputs drive this block's request inputs.

Parameters:
ADDR_W, 16, request/load address width
DATA_W, 16, weight/bias word width (signed fixed-point, opaque here)
W_DEPTH, 4096, weight bank entries
B_DEPTH, 256, bias bank entries

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
load_start  in  1  pulse: enter LOAD, invalidate tables
load_valid  in  1  load word present
load_sel  in  1  0=weight bank, 1=bias bank
load_addr  in  ADDR_W  load target address
load_data  in  DATA_W  load word
load_done  in  1  pulse: finish LOAD
load_ready  out  1  high in LOAD state
tables_valid  out  1  high in SERVE state
read_weight_signal  in  1  weight read request
read_weight_addr  in  ADDR_W  weight read address
read_bias_signal  in  1  bias read request
read_bias_addr  in  ADDR_W  bias read address
weight_data  out  DATA_W  returned weight
weight_valid  out  1  weight_data valid, 1 cycle
bias_data  out  DATA_W  returned bias
bias_valid  out  1  bias_data valid, 1 cycle
addr_err  out  1  sticky: out-of-range access or read outside SERVE

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all outputs 0; addr_err cleared; bank contents undefined (not reset).
- FSM states IDLE, LOAD, SERVE:
  - IDLE -> LOAD on load_start.
  - LOAD -> SERVE on load_done.
  - SERVE -> LOAD on load_start, reload permitted.
  - load_start and load_done in the same cycle: load_start wins.
- LOAD:
  - load_ready=1. Each cycle with load_valid=1 writes load_data into the selected bank at load_addr.
  - load_addr >= depth of the selected bank: write dropped, addr_err set.
  - Read requests in LOAD or IDLE: no valid returned, addr_err set.
- load_valid on the load_done cycle: the word is written, then the state enters SERVE.
- SERVE:
  - Request with read_weight_signal=1 in cycle N: weight_valid=1 in N+1, weight_data=W[addr].
  - Bias path is independent and identical.
  - Both paths may fire in the same cycle.
  - Back-to-back requests are fully pipelined: one result per cycle, no bubbles.
- Out-of-range read (addr >= depth): valid still asserted at N+1, data=0, addr_err set.
- Read and load never coexist, so there is no read/write collision.
- Without a request, valid=0 and data holds its last value.
- addr_err is cleared only by reset or load_start.
- load_start while a read result is in flight: that result still returns in N+1. SERVE-only gating applies at request time.
- Widths: addresses compared unsigned. Data passes through unmodified.

Decomposition:
- Package wb_pkg:
  - ADDR_W, DATA_W, W_DEPTH, B_DEPTH defaults.
  - wb_state_e enum {IDLE, LOAD, SERVE}.
  - Bank-select constants WB_SEL_WEIGHT=0, WB_SEL_BIAS=1.
- Sub-module wb_bank:
  - Parameterised DEPTH/width.
  - Single port: sync write, sync registered read, range check producing oob.
  - Instantiated twice (weight, bias).
- Top holds the FSM, load steering, valid pipeline and addr_err.

Test Plan:
- Reset: assert rst_n=0 mid-SERVE with requests active -> all outputs 0 immediately, state IDLE; a subsequent read -> no valid, addr_err=1.
- Load/serve: load W[0..3]=16'h0011..16'h0044 and B[0]=16'h8001, then load_done; read weight addr 2 at cycle N -> weight_valid=1 and weight_data=16'h0033 at N+1.
- Streaming: weight reads addr 0,1,2,3 back-to-back plus a bias read addr 0 in the first cycle -> weight data 0011,0022,0033,0044 in consecutive cycles; bias_data=8001 alongside 0011.
- Out of range: read weight addr 4096 in SERVE -> weight_valid=1, weight_data=0, addr_err=1. A load to bias addr 300 -> no write, addr_err=1.
- Boundary/priority: load_start and load_done in the same cycle -> state LOAD, load_ready=1. load_valid on the load_done cycle writing W[5]=16'h0B0B -> a later read of addr 5 returns 0B0B.
- Reload: SERVE -> load_start -> overwrite W[0]=16'hFFFF -> load_done -> read addr 0 returns FFFF; addr_err was cleared at load_start.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared definitions for the weight/bias responder.
// Holds the default geometry, the FSM state type and the bank-select
// encoding used on the load port.
package wb_pkg;

    localparam int WB_ADDR_W  = 16;
    localparam int WB_DATA_W  = 16;
    localparam int WB_W_DEPTH = 4096;
    localparam int WB_B_DEPTH = 256;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SERVE = 2'd2
    } wb_state_e;

    localparam logic WB_SEL_WEIGHT = 1'b0;
    localparam logic WB_SEL_BIAS   = 1'b1;

endpackage

// File: rtl/weight_bias_responder_if.sv
// Read request/response bundle between the weight/bias arbiter (master)
// and the weight/bias responder (slave).
//   read_weight_signal/addr, read_bias_signal/addr : requests, master -> slave
//   weight_data/valid, bias_data/valid             : results,  slave -> master
interface weight_bias_responder_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              read_weight_signal;
    logic [ADDR_W-1:0] read_weight_addr;
    logic              read_bias_signal;
    logic [ADDR_W-1:0] read_bias_addr;
    logic [DATA_W-1:0] weight_data;
    logic              weight_valid;
    logic [DATA_W-1:0] bias_data;
    logic              bias_valid;

    modport master (
        output read_weight_signal, read_weight_addr,
        output read_bias_signal,   read_bias_addr,
        input  weight_data, weight_valid,
        input  bias_data,   bias_valid
    );

    modport slave (
        input  read_weight_signal, read_weight_addr,
        input  read_bias_signal,   read_bias_addr,
        output weight_data, weight_valid,
        output bias_data,   bias_valid
    );
endinterface

// File: rtl/wb_bank.sv
// Single-port table bank: synchronous write, registered synchronous read.
// oob_o flags any address at or beyond DEPTH; out-of-range writes are
// dropped and out-of-range reads return zero.
// Ports:
//   clk, rst_n     : clock, async active-low reset (read register only)
//   en_i, we_i     : access enable, write (1) / read (0)
//   addr_i         : access address
//   wdata_i        : write word
//   rdata_o        : registered read word, holds between reads
//   oob_o          : combinational out-of-range flag for addr_i
module wb_bank #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              oob_o
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;
    logic [IDX_W-1:0]  idx;

    assign oob_o   = ({1'b0, addr_i} >= DEPTH_A);
    assign idx     = addr_i[IDX_W-1:0];
    assign rdata_o = rdata_q;

    // Table contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (en_i && we_i && !oob_o) begin
            mem[idx] <= wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (en_i && !we_i) begin
            rdata_q <= oob_o ? '0 : mem[idx];
        end
    end
endmodule

// File: rtl/weight_bias_responder.sv
// Memory-side responder for arbitrated weight/bias reads.
// Two internal banks are filled over the load port while in LOAD, then
// served with a fixed one-cycle latency while in SERVE.
// Ports:
//   clk, rst_n              : clock, async active-low reset
//   load_start / load_done  : enter / leave LOAD (load_start has priority)
//   load_valid/sel/addr/data: one bank write per cycle in LOAD
//   load_ready              : high while in LOAD
//   tables_valid            : high while in SERVE
//   addr_err                : sticky out-of-range or out-of-state access
//   rd                      : read request/response bundle (slave side)
module weight_bias_responder
    import wb_pkg::*;
#(
    parameter int ADDR_W  = WB_ADDR_W,
    parameter int DATA_W  = WB_DATA_W,
    parameter int W_DEPTH = WB_W_DEPTH,
    parameter int B_DEPTH = WB_B_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load_start,
    input  logic                     load_valid,
    input  logic                     load_sel,
    input  logic [ADDR_W-1:0]        load_addr,
    input  logic [DATA_W-1:0]        load_data,
    input  logic                     load_done,
    output logic                     load_ready,
    output logic                     tables_valid,
    output logic                     addr_err,
    weight_bias_responder_if.slave   rd
);
    wb_state_e state_q;
    logic      load_ready_q;
    logic      tables_valid_q;
    logic      weight_valid_q;
    logic      bias_valid_q;
    logic      addr_err_q;
    logic      addr_err_d;

    logic              in_load;
    logic              in_serve;
    logic              w_load_wr, b_load_wr;
    logic              w_rd, b_rd;
    logic              w_en, b_en;
    logic [ADDR_W-1:0] w_addr, b_addr;
    logic [DATA_W-1:0] w_rdata, b_rdata;
    logic              w_oob, b_oob;
    logic              err_set;

    assign in_load  = (state_q == LOAD);
    assign in_serve = (state_q == SERVE);

    // Load writes and reads are mutually exclusive by state, so each bank
    // simply takes its address from whichever side the state selects.
    assign w_load_wr = in_load && load_valid && (load_sel == WB_SEL_WEIGHT);
    assign b_load_wr = in_load && load_valid && (load_sel == WB_SEL_BIAS);
    assign w_rd      = in_serve && rd.read_weight_signal;
    assign b_rd      = in_serve && rd.read_bias_signal;
    assign w_en      = w_load_wr || w_rd;
    assign b_en      = b_load_wr || b_rd;
    assign w_addr    = in_load ? load_addr : rd.read_weight_addr;
    assign b_addr    = in_load ? load_addr : rd.read_bias_addr;

    wb_bank #(
        .DEPTH  (W_DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_weight_bank (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (w_en),
        .we_i    (w_load_wr),
        .addr_i  (w_addr),
        .wdata_i (load_data),
        .rdata_o (w_rdata),
        .oob_o   (w_oob)
    );

    wb_bank #(
        .DEPTH  (B_DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_bias_bank (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (b_en),
        .we_i    (b_load_wr),
        .addr_i  (b_addr),
        .wdata_i (load_data),
        .rdata_o (b_rdata),
        .oob_o   (b_oob)
    );

    // FSM with registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            load_ready_q   <= 1'b0;
            tables_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (load_start) begin
                        state_q      <= LOAD;
                        load_ready_q <= 1'b1;
                    end
                end
                LOAD: begin
                    // load_start overrides a simultaneous load_done.
                    if (!load_start && load_done) begin
                        state_q        <= SERVE;
                        load_ready_q   <= 1'b0;
                        tables_valid_q <= 1'b1;
                    end
                end
                SERVE: begin
                    if (load_start) begin
                        state_q        <= LOAD;
                        load_ready_q   <= 1'b1;
                        tables_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q        <= IDLE;
                    load_ready_q   <= 1'b0;
                    tables_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // An error event in the load_start cycle still latches, so nothing is lost.
    assign err_set = (w_load_wr && w_oob) || (b_load_wr && b_oob)
                  || (w_rd && w_oob) || (b_rd && b_oob)
                  || (!in_serve && (rd.read_weight_signal || rd.read_bias_signal));

    always_comb begin
        addr_err_d = load_start ? 1'b0 : addr_err_q;
        if (err_set) begin
            addr_err_d = 1'b1;
        end
    end

    // Valid strobes are qualified at request time, so a result issued in
    // the same cycle as load_start still returns.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            weight_valid_q <= 1'b0;
            bias_valid_q   <= 1'b0;
            addr_err_q     <= 1'b0;
        end else begin
            weight_valid_q <= w_rd;
            bias_valid_q   <= b_rd;
            addr_err_q     <= addr_err_d;
        end
    end

    assign load_ready      = load_ready_q;
    assign tables_valid    = tables_valid_q;
    assign addr_err        = addr_err_q;
    assign rd.weight_data  = w_rdata;
    assign rd.weight_valid = weight_valid_q;
    assign rd.bias_data    = b_rdata;
    assign rd.bias_valid   = bias_valid_q;
endmodule

// File: tb/tb_weight_bias_responder.sv
// Directed bench for weight_bias_responder: load, serve, streaming,
// out-of-range, priority, reload, in-flight and reset behaviour.
module tb_weight_bias_responder;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;

    logic              clk;
    logic              rst_n;
    logic              load_start;
    logic              load_valid;
    logic              load_sel;
    logic [ADDR_W-1:0] load_addr;
    logic [DATA_W-1:0] load_data;
    logic              load_done;
    logic              load_ready;
    logic              tables_valid;
    logic              addr_err;

    int n_checks = 0;
    int n_err    = 0;

    weight_bias_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) rd_if ();

    weight_bias_responder #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .W_DEPTH (4096),
        .B_DEPTH (256)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_start   (load_start),
        .load_valid   (load_valid),
        .load_sel     (load_sel),
        .load_addr    (load_addr),
        .load_data    (load_data),
        .load_done    (load_done),
        .load_ready   (load_ready),
        .tables_valid (tables_valid),
        .addr_err     (addr_err),
        .rd           (rd_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic sel, input logic [15:0] addr, input logic [15:0] data);
        load_valid = 1'b1;
        load_sel   = sel;
        load_addr  = addr;
        load_data  = data;
        tick();
        load_valid = 1'b0;
    endtask

    task automatic read_w(input logic [15:0] addr);
        rd_if.read_weight_signal = 1'b1;
        rd_if.read_weight_addr   = addr;
        tick();
        rd_if.read_weight_signal = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] stream_exp [4];
        stream_exp[0] = 16'h0011;
        stream_exp[1] = 16'h0022;
        stream_exp[2] = 16'h0033;
        stream_exp[3] = 16'h0044;

        rst_n = 1'b0;
        load_start = 1'b0; load_valid = 1'b0; load_sel = 1'b0;
        load_addr = '0; load_data = '0; load_done = 1'b0;
        rd_if.read_weight_signal = 1'b0; rd_if.read_weight_addr = '0;
        rd_if.read_bias_signal   = 1'b0; rd_if.read_bias_addr   = '0;
        tick(); tick();

        check("rst_load_ready",   32'(load_ready),   0);
        check("rst_tables_valid", 32'(tables_valid), 0);
        check("rst_addr_err",     32'(addr_err),     0);
        check("rst_weight_valid", 32'(rd_if.weight_valid), 0);
        check("rst_weight_data",  32'(rd_if.weight_data),  0);
        rst_n = 1'b1;
        tick();

        // Initial load
        load_start = 1'b1; tick(); load_start = 1'b0;
        check("load_ready_in_load", 32'(load_ready),   1);
        check("tv_in_load",         32'(tables_valid), 0);
        for (int i = 0; i < 4; i++) load_word(1'b0, 16'(i), stream_exp[i]);
        load_word(1'b1, 16'd0, 16'h8001);
        load_done = 1'b1; tick(); load_done = 1'b0;
        check("serve_load_ready", 32'(load_ready),   0);
        check("serve_tv",         32'(tables_valid), 1);
        check("serve_err_clean",  32'(addr_err),     0);

        // Single read, then hold
        read_w(16'd2);
        check("rd2_valid", 32'(rd_if.weight_valid), 1);
        check("rd2_data",  32'(rd_if.weight_data),  'h33);
        tick();
        check("idle_valid", 32'(rd_if.weight_valid), 0);
        check("idle_hold",  32'(rd_if.weight_data),  'h33);

        // Streaming with a bias read in the first cycle
        for (int i = 0; i < 4; i++) begin
            rd_if.read_weight_signal = 1'b1;
            rd_if.read_weight_addr   = 16'(i);
            rd_if.read_bias_signal   = (i == 0);
            rd_if.read_bias_addr     = '0;
            tick();
            check($sformatf("stream_v%0d", i), 32'(rd_if.weight_valid), 1);
            check($sformatf("stream_d%0d", i), 32'(rd_if.weight_data),  32'(stream_exp[i]));
            check($sformatf("stream_bv%0d", i), 32'(rd_if.bias_valid), (i == 0) ? 1 : 0);
            if (i == 0) check("stream_bd", 32'(rd_if.bias_data), 'h8001);
        end
        rd_if.read_weight_signal = 1'b0;
        rd_if.read_bias_signal   = 1'b0;
        tick();
        check("stream_end_valid", 32'(rd_if.weight_valid), 0);
        check("stream_err_clean", 32'(addr_err), 0);

        // Out-of-range weight read
        read_w(16'd4096);
        check("oob_valid", 32'(rd_if.weight_valid), 1);
        check("oob_data",  32'(rd_if.weight_data),  0);
        check("oob_err",   32'(addr_err),           1);

        // Reload: error cleared at load_start, out-of-range bias load
        load_start = 1'b1; tick(); load_start = 1'b0;
        check("reload_err_clr", 32'(addr_err),   0);
        check("reload_ready",   32'(load_ready), 1);
        load_word(1'b1, 16'd300, 16'h1234);
        check("bias_oob_load_err", 32'(addr_err), 1);

        // load_start and load_done together: stay in LOAD
        load_start = 1'b1; load_done = 1'b1; tick();
        load_start = 1'b0; load_done = 1'b0;
        check("prio_ready", 32'(load_ready),   1);
        check("prio_tv",    32'(tables_valid), 0);
        check("prio_err",   32'(addr_err),     0);

        // Read while in LOAD: no valid, error
        read_w(16'd1);
        check("load_rd_valid", 32'(rd_if.weight_valid), 0);
        check("load_rd_err",   32'(addr_err),           1);

        // Overwrite W[0], then write W[5] on the load_done cycle
        load_word(1'b0, 16'd0, 16'hFFFF);
        load_valid = 1'b1; load_sel = 1'b0; load_addr = 16'd5; load_data = 16'h0B0B;
        load_done = 1'b1; tick();
        load_valid = 1'b0; load_done = 1'b0;
        check("done_tv", 32'(tables_valid), 1);

        read_w(16'd5);
        check("w5_data", 32'(rd_if.weight_data), 'h0B0B);
        read_w(16'd0);
        check("w0_reload", 32'(rd_if.weight_data), 'hFFFF);
        read_w(16'd3);
        check("w3_kept", 32'(rd_if.weight_data), 'h44);
        rd_if.read_bias_signal = 1'b1; rd_if.read_bias_addr = 16'd0; tick();
        rd_if.read_bias_signal = 1'b0;
        check("b0_kept", 32'(rd_if.bias_data), 'h8001);

        // Read issued in the load_start cycle still returns
        rd_if.read_weight_signal = 1'b1; rd_if.read_weight_addr = 16'd1;
        load_start = 1'b1; tick();
        rd_if.read_weight_signal = 1'b0; load_start = 1'b0;
        check("inflight_valid", 32'(rd_if.weight_valid), 1);
        check("inflight_data",  32'(rd_if.weight_data),  'h22);
        check("inflight_ready", 32'(load_ready),         1);
        load_done = 1'b1; tick(); load_done = 1'b0;

        // Reset mid-SERVE with requests active
        rd_if.read_weight_signal = 1'b1; rd_if.read_weight_addr = 16'd3;
        rd_if.read_bias_signal   = 1'b1; rd_if.read_bias_addr   = 16'd0;
        tick();
        check("pre_rst_valid", 32'(rd_if.weight_valid), 1);
        rst_n = 1'b0;
        #1;
        check("async_rst_wv", 32'(rd_if.weight_valid), 0);
        check("async_rst_wd", 32'(rd_if.weight_data),  0);
        check("async_rst_bv", 32'(rd_if.bias_valid),   0);
        check("async_rst_bd", 32'(rd_if.bias_data),    0);
        check("async_rst_tv", 32'(tables_valid),       0);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_valid", 32'(rd_if.weight_valid), 0);
        check("post_rst_err",   32'(addr_err),           1);
        rd_if.read_weight_signal = 1'b0;
        rd_if.read_bias_signal   = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
